// File: rtl/rtc_clock.sv
// Seconds timekeeper: keeps unix time from host loads or Mac writes and advances it
// once every CLK_HZ cycles. It also drives the RTC timestamp input and the VIA CA2 1 Hz wave.
module rtc_clock #(
    parameter longint unsigned CLK_HZ    = 32000000,
    parameter logic [31:0]     EPOCH_OFS = 32'h7C25B080
) (
    input  logic        clk,
    input  logic        _reset,
    input  logic [32:0] timestamp,
    input  logic        wr,
    input  logic [31:0] wr_secs,
    output logic [32:0] ts_o,
    output logic [31:0] secs,
    output logic        valid,
    output logic        one_sec,
    output logic        onesec_sq
);

    localparam logic [31:0] TERM = 32'(CLK_HZ - 1);
    localparam logic [31:0] HALF = 32'(CLK_HZ / 2);

    logic [31:0] presc_q, presc_d;
    logic [31:0] unix_q, unix_d;
    logic        tog_q, tog_d;
    logic        valid_q, valid_d;
    logic        one_sec_q, one_sec_d;
    logic        sq_q, sq_d;
    logic        host_load;

    assign host_load = timestamp[32] != tog_q;

    always_comb begin
        presc_d   = presc_q + 32'd1;
        unix_d    = unix_q;
        tog_d     = tog_q;
        valid_d   = valid_q;
        one_sec_d = 1'b0;
        if (host_load) begin
            unix_d  = timestamp[31:0];
            tog_d   = timestamp[32];
            presc_d = '0;
            valid_d = 1'b1;
        end else if (wr) begin
            unix_d  = wr_secs - EPOCH_OFS;
            presc_d = '0;
            valid_d = 1'b1;
        end else if (presc_q == TERM) begin
            presc_d   = '0;
            unix_d    = unix_q + 32'd1;
            one_sec_d = 1'b1;
        end
        // Derived from the next prescaler value so loads realign the wave too.
        sq_d = presc_d < HALF;
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            presc_q   <= '0;
            unix_q    <= '0;
            tog_q     <= 1'b0;
            valid_q   <= 1'b0;
            one_sec_q <= 1'b0;
            sq_q      <= 1'b1;
        end else begin
            presc_q   <= presc_d;
            unix_q    <= unix_d;
            tog_q     <= tog_d;
            valid_q   <= valid_d;
            one_sec_q <= one_sec_d;
            sq_q      <= sq_d;
        end
    end

    assign ts_o      = {valid_q, unix_q};
    assign secs      = unix_q + EPOCH_OFS;
    assign valid     = valid_q;
    assign one_sec   = one_sec_q;
    assign onesec_sq = sq_q;

endmodule

// File: tb/tb_rtc_clock.sv
// Bench for rtc_clock with CLK_HZ=8: a vector table runs through a scoreboard queue,
// and hand-written sequences cover reset and async reset in mid-second.
module tb_rtc_clock;

    localparam logic [31:0] E = 32'h7C25B080;

    logic        clk = 1'b0;
    logic        _reset = 1'b0;
    logic [32:0] timestamp = '0;
    logic        wr = 1'b0;
    logic [31:0] wr_secs = '0;
    logic [32:0] ts_o;
    logic [31:0] secs;
    logic        valid, one_sec, onesec_sq;

    rtc_clock #(.CLK_HZ(8), .EPOCH_OFS(32'h7C25B080)) dut (
        .clk(clk), ._reset(_reset), .timestamp(timestamp), .wr(wr), .wr_secs(wr_secs),
        .ts_o(ts_o), .secs(secs), .valid(valid), .one_sec(one_sec), .onesec_sq(onesec_sq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [32:0] ts_in;
        logic        wr;
        logic [31:0] ws;
        logic [32:0] e_ts;
        logic [31:0] e_secs;
        logic        e_os;
        logic        e_sq;
    } vec_t;

    typedef struct {
        logic [32:0] ts;
        logic [31:0] secs;
        logic        os;
        logic        sq;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void v(input logic [32:0] ti, input logic w, input logic [31:0] ws,
                              input logic [32:0] ets, input logic [31:0] es,
                              input logic eos, input logic esq);
        vec_t x;
        x.ts_in = ti; x.wr = w; x.ws = ws;
        x.e_ts = ets; x.e_secs = es; x.e_os = eos; x.e_sq = esq;
        vecs.push_back(x);
    endfunction

    task automatic step(input vec_t x, input string tag);
        exp_t e;
        e.ts = x.e_ts; e.secs = x.e_secs; e.os = x.e_os; e.sq = x.e_sq;
        sb.push_back(e);
        timestamp = x.ts_in;
        wr        = x.wr;
        wr_secs   = x.ws;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".ts_o"}, 64'(ts_o), 64'(e.ts));
        chk({tag, ".secs"}, 64'(secs), 64'(e.secs));
        chk({tag, ".valid"}, 64'(valid), 64'(e.ts[32]));
        chk({tag, ".one_sec"}, 64'(one_sec), 64'(e.os));
        chk({tag, ".onesec_sq"}, 64'(onesec_sq), 64'(e.sq));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".ts_o"}, 64'(ts_o), 64'd0);
        chk({tag, ".secs"}, 64'(secs), 64'(E));
        chk({tag, ".valid"}, 64'(valid), 64'd0);
        chk({tag, ".one_sec"}, 64'(one_sec), 64'd0);
        chk({tag, ".onesec_sq"}, 64'(onesec_sq), 64'd1);
    endtask

    initial begin
        vec_t x;
        int n;
        bit seen;

        // Free run from reset: first tick on edge 8, wave low on edges 4..7.
        for (int i = 1; i <= 7; i++) v(33'h0, 0, 0, 33'h0, E, 0, i < 4);
        v(33'h0, 0, 0, 33'h0_00000001, 32'h7C25B081, 1, 1);
        for (int i = 1; i <= 2; i++) v(33'h0, 0, 0, 33'h0_00000001, 32'h7C25B081, 0, 1);
        // Host load mid-second restarts the second.
        v(33'h1_65000000, 0, 0, 33'h1_65000000, 32'hE125B080, 0, 1);
        for (int i = 1; i <= 7; i++) v(33'h1_65000000, 0, 0, 33'h1_65000000, 32'hE125B080, 0, i < 4);
        v(33'h1_65000000, 0, 0, 33'h1_65000001, 32'hE125B081, 1, 1);
        // Mac write in Mac-epoch seconds.
        v(33'h1_65000000, 1, 32'h7C25B085, 33'h1_00000005, 32'h7C25B085, 0, 1);
        for (int i = 1; i <= 7; i++) v(33'h1_65000000, 0, 0, 33'h1_00000005, 32'h7C25B085, 0, i < 4);
        v(33'h1_65000000, 0, 0, 33'h1_00000006, 32'h7C25B086, 1, 1);
        // Bring presc to 7, then toggle + wr + terminal count together.
        for (int i = 1; i <= 7; i++) v(33'h1_65000000, 0, 0, 33'h1_00000006, 32'h7C25B086, 0, i < 4);
        v(33'h0_12345678, 1, 32'hDEADBEEF, 33'h1_12345678, 32'h8E5A06F8, 0, 1);
        v(33'h0_12345678, 0, 0, 33'h1_12345678, 32'h8E5A06F8, 0, 1);
        // Wrap 0xFFFFFFFF -> 0.
        v(33'h1_FFFFFFFF, 0, 0, 33'h1_FFFFFFFF, 32'h7C25B07F, 0, 1);
        for (int i = 1; i <= 7; i++) v(33'h1_FFFFFFFF, 0, 0, 33'h1_FFFFFFFF, 32'h7C25B07F, 0, i < 4);
        v(33'h1_FFFFFFFF, 0, 0, 33'h1_00000000, E, 1, 1);
        // Run to presc=5 for the async reset sequence.
        for (int i = 1; i <= 5; i++) v(33'h1_FFFFFFFF, 0, 0, 33'h1_00000000, E, 0, i < 4);

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        _reset = 1'b1;

        foreach (vecs[i]) begin
            x = vecs[i];
            step(x, $sformatf("vec%0d", i));
        end

        // Async reset with no clock edge, then exactly 8 edges to the first tick.
        #2;
        _reset = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        timestamp = 33'h0;
        @(negedge clk);
        _reset = 1'b1;
        n = 0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk);
            #1;
            n++;
            if (one_sec) seen = 1;
        end
        chk("async_rst.tick_seen", 64'(seen), 64'd1);
        chk("async_rst.tick_edges", 64'(n), 64'd8);
        chk("async_rst.ts_o", 64'(ts_o), 64'h0_00000001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
